wb_stage: RTL and testbench

Writeback pipeline stage. It sits at the far end of the pipeline and produces the register-file write port that the decode stage consumes: RegWrite, write address and write data. It registers the MEM/WB boundary and aligns and extends load data. It also owns the HI/LO registers fed by the multi-cycle multiplier, and stalls the pipe when HI/LO is read while a multiply is still running.

---
 rtl/wb_stage.sv | 121 ++++++++++++
 tb/tb_wb_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: registers MEM/WB, aligns and extends big-endian load data,
// and owns HI/LO with a two-state interlock against the multi-cycle multiplier.
module wb_stage (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Valid,
  input  logic        RegWriteIn,
  input  logic        MemtoReg,
  input  logic [4:0]  RAddrIn,
  input  logic [31:0] ALUResult,
  input  logic [31:0] MemData,
  input  logic [1:0]  LoadSize,
  input  logic        LoadSigned,
  input  logic [1:0]  ByteOffset,
  input  logic        MulStart,
  input  logic        MulDone,
  input  logic [31:0] MulHi,
  input  logic [31:0] MulLo,
  input  logic        MfHi,
  input  logic        MfLo,
  output logic        RegWrite,
  output logic [4:0]  RAddr,
  output logic [31:0] RData,
  output logic        Stall
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        accept;
  logic        mul_accept;
  logic        write_en;
  logic [31:0] wdata;

  function automatic logic [31:0] align_load(input logic [31:0] d, input logic [1:0] size,
                                             input logic sgn, input logic [1:0] off);
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] r;
    h = off[1] ? d[15:0] : d[31:16];
    case (off)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      2'd3:    b = d[7:0];
      default: b = d[7:0];
    endcase
    case (size)
      2'b01:   r = {{16{sgn & h[15]}}, h};
      2'b10:   r = {{24{sgn & b[7]}}, b};
      default: r = d;
    endcase
    return r;
  endfunction

  assign busy       = (state == BUSY);
  assign Stall      = Valid & busy & ~MulDone & (MfHi | MfLo | MulStart);
  assign accept     = Valid & ~Stall;
  assign mul_accept = accept & MulStart;
  assign write_en   = (RegWriteIn | MfHi | MfLo) & (RAddrIn != 5'd0);

  // Next-state logic for the multiplier tracker
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (mul_accept) state_next = BUSY;
        else            state_next = IDLE;
      end
      BUSY: begin
        if (MulDone) state_next = mul_accept ? BUSY : IDLE;
        else         state_next = BUSY;
      end
      default: state_next = IDLE;
    endcase
  end

  // Write-data select: HI/LO (with same-cycle bypass), then load, then ALU
  always_comb begin
    wdata = ALUResult;
    if (MfHi)          wdata = (MulDone && busy) ? MulHi : hi;
    else if (MfLo)     wdata = (MulDone && busy) ? MulLo : lo;
    else if (MemtoReg) wdata = align_load(MemData, LoadSize, LoadSigned, ByteOffset);
    else               wdata = ALUResult;
  end

  // State register and HI/LO capture; a MulDone seen outside BUSY is dropped
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      state <= state_next;
      if (busy && MulDone) begin
        hi <= MulHi;
        lo <= MulLo;
      end
    end
  end

  // Register-file write port; address/data hold while stalled or invalid
  always_ff @(posedge Clock) begin
    if (Reset) begin
      RegWrite <= 1'b0;
      RAddr    <= 5'd0;
      RData    <= 32'd0;
    end else if (accept) begin
      RegWrite <= write_en;
      RAddr    <= RAddrIn;
      RData    <= wdata;
    end else begin
      RegWrite <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: reset, ALU/$0 writes, load
// alignment, multiply interlock with bypass, back-to-back multiply, reset mid-multiply.
module tb_wb_stage;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Valid, RegWriteIn, MemtoReg, LoadSigned;
  logic        MulStart, MulDone, MfHi, MfLo;
  logic [4:0]  RAddrIn;
  logic [31:0] ALUResult, MemData, MulHi, MulLo;
  logic [1:0]  LoadSize, ByteOffset;
  logic        RegWrite, Stall;
  logic [4:0]  RAddr;
  logic [31:0] RData;

  int n_checks = 0;
  int n_pass   = 0;

  wb_stage dut (
    .Clock(Clock), .Reset(Reset), .Valid(Valid), .RegWriteIn(RegWriteIn),
    .MemtoReg(MemtoReg), .RAddrIn(RAddrIn), .ALUResult(ALUResult), .MemData(MemData),
    .LoadSize(LoadSize), .LoadSigned(LoadSigned), .ByteOffset(ByteOffset),
    .MulStart(MulStart), .MulDone(MulDone), .MulHi(MulHi), .MulLo(MulLo),
    .MfHi(MfHi), .MfLo(MfLo), .RegWrite(RegWrite), .RAddr(RAddr), .RData(RData),
    .Stall(Stall)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic clear();
    Valid = 1'b0; RegWriteIn = 1'b0; MemtoReg = 1'b0; LoadSigned = 1'b0;
    MulStart = 1'b0; MulDone = 1'b0; MfHi = 1'b0; MfLo = 1'b0;
    RAddrIn = 5'd0; ALUResult = 32'd0; MemData = 32'd0; MulHi = 32'd0; MulLo = 32'd0;
    LoadSize = 2'b00; ByteOffset = 2'b00;
  endtask

  task automatic do_load(input string tag, input logic [1:0] size, input logic sgn,
                         input logic [1:0] off, input logic [31:0] exp);
    clear();
    Valid = 1'b1; RegWriteIn = 1'b1; MemtoReg = 1'b1; RAddrIn = 5'd3;
    MemData = 32'h8123F4A5; ALUResult = 32'h0BAD0BAD;
    LoadSize = size; LoadSigned = sgn; ByteOffset = off;
    step();
    check(tag, RData, exp);
  endtask

  initial begin
    clear();
    Reset = 1'b1;
    step(); step();
    Reset = 1'b0;
    check("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    check("rst_raddr", {27'd0, RAddr}, 32'd0);
    check("rst_rdata", RData, 32'd0);
    check("rst_stall", {31'd0, Stall}, 32'd0);

    // MFHI right after reset reads HI=0
    Valid = 1'b1; MfHi = 1'b1; RegWriteIn = 1'b1; RAddrIn = 5'd5;
    step();
    check("mfhi_rst_we", {31'd0, RegWrite}, 32'd1);
    check("mfhi_rst_addr", {27'd0, RAddr}, 32'd5);
    check("mfhi_rst_data", RData, 32'd0);

    // ALU write and $0 suppression
    clear();
    Valid = 1'b1; RegWriteIn = 1'b1; RAddrIn = 5'd8; ALUResult = 32'hDEADBEEF;
    step();
    check("alu_we", {31'd0, RegWrite}, 32'd1);
    check("alu_data", RData, 32'hDEADBEEF);
    RAddrIn = 5'd0;
    step();
    check("r0_we", {31'd0, RegWrite}, 32'd0);
    check("r0_addr", {27'd0, RAddr}, 32'd0);

    // Invalid cycle writes nothing
    clear();
    RegWriteIn = 1'b1; RAddrIn = 5'd4;
    step();
    check("invalid_we", {31'd0, RegWrite}, 32'd0);

    do_load("ld_b1_s", 2'b10, 1'b1, 2'd1, 32'h00000023);
    do_load("ld_b2_s", 2'b10, 1'b1, 2'd2, 32'hFFFFFFF4);
    do_load("ld_b3_u", 2'b10, 1'b0, 2'd3, 32'h000000A5);
    do_load("ld_h2_u", 2'b01, 1'b0, 2'd2, 32'h0000F4A5);
    do_load("ld_h0_s", 2'b01, 1'b1, 2'd0, 32'hFFFF8123);
    do_load("ld_h1_s", 2'b01, 1'b1, 2'd1, 32'hFFFF8123);
    do_load("ld_w", 2'b00, 1'b1, 2'd3, 32'h8123F4A5);
    do_load("ld_sz3", 2'b11, 1'b1, 2'd1, 32'h8123F4A5);

    // Multiply interlock: MULT, MFLO stalls two cycles, MulDone bypasses LO
    clear();
    Valid = 1'b1; MulStart = 1'b1;
    step();
    check("mult_we", {31'd0, RegWrite}, 32'd0);
    clear();
    Valid = 1'b1; MfLo = 1'b1; RegWriteIn = 1'b1; RAddrIn = 5'd9;
    #1;
    check("mflo_stall1", {31'd0, Stall}, 32'd1);
    step();
    check("mflo_stall_we1", {31'd0, RegWrite}, 32'd0);
    check("mflo_stall2", {31'd0, Stall}, 32'd1);
    step();
    check("mflo_stall_we2", {31'd0, RegWrite}, 32'd0);
    MulDone = 1'b1; MulLo = 32'h00001234; MulHi = 32'h0000AAAA;
    #1;
    check("mflo_done_stall", {31'd0, Stall}, 32'd0);
    step();
    clear();
    check("mflo_we", {31'd0, RegWrite}, 32'd1);
    check("mflo_addr", {27'd0, RAddr}, 32'd9);
    check("mflo_bypass", RData, 32'h00001234);
    step();
    check("mflo_one_pulse", {31'd0, RegWrite}, 32'd0);
    Valid = 1'b1; MfLo = 1'b1; RegWriteIn = 1'b1; RAddrIn = 5'd9;
    #1;
    check("idle_mflo_stall", {31'd0, Stall}, 32'd0);
    step();
    check("lo_reg", RData, 32'h00001234);

    // Back-to-back multiply: MulStart in the MulDone cycle is accepted
    clear();
    Valid = 1'b1; MulStart = 1'b1;
    step();
    clear();
    step();
    Valid = 1'b1; MulStart = 1'b1; MulDone = 1'b1; MulHi = 32'd7; MulLo = 32'd8;
    #1;
    check("b2b_stall", {31'd0, Stall}, 32'd0);
    step();
    check("b2b_hi", dut.hi, 32'd7);
    clear();
    Valid = 1'b1; MfHi = 1'b1; RegWriteIn = 1'b1; RAddrIn = 5'd10;
    #1;
    check("b2b_busy_stall", {31'd0, Stall}, 32'd1);
    step();
    check("b2b_stall_we", {31'd0, RegWrite}, 32'd0);
    MulDone = 1'b1; MulHi = 32'h00000099; MulLo = 32'h00000098;
    step();
    clear();
    check("b2b_mfhi_we", {31'd0, RegWrite}, 32'd1);
    check("b2b_mfhi_data", RData, 32'h00000099);

    // Reset mid-multiply releases the stall and drops the late MulDone
    Valid = 1'b1; MulStart = 1'b1;
    step();
    clear();
    Valid = 1'b1; MfHi = 1'b1; RegWriteIn = 1'b1; RAddrIn = 5'd11;
    #1;
    check("rmm_stall", {31'd0, Stall}, 32'd1);
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    #1;
    check("rmm_stall_released", {31'd0, Stall}, 32'd0);
    check("rmm_we", {31'd0, RegWrite}, 32'd0);
    clear();
    MulDone = 1'b1; MulHi = 32'h00000055; MulLo = 32'h00000056;
    step();
    clear();
    Valid = 1'b1; MfHi = 1'b1; RegWriteIn = 1'b1; RAddrIn = 5'd11;
    step();
    check("rmm_mfhi_we", {31'd0, RegWrite}, 32'd1);
    check("rmm_mfhi_data", RData, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
